pipelined_carry_select_sub: RTL and testbench

//  Pipelined, back-pressurable carry-select subtractor: d = a - b - bi, with borrow out and signed overflow.

---
 rtl/fixed_point_arith_pkg.sv | 21 ++
 rtl/csel_sub_slice.sv | 36 +++
 rtl/pipelined_carry_select_sub.sv | 130 +++++++++++++
 tb/tb_pipelined_carry_select_sub.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_arith_pkg.sv
// ============================================================================
// fixed_point_arith_pkg
// Shared sizing helpers and slice result type for the fixed-point datapaths.
// Revision: 1.0
// ============================================================================
`default_nettype none

// Packages cannot hold parameterised types, so each user instantiates this at its own slice width.
`ifndef FPA_SLICE_RES_T
`define FPA_SLICE_RES_T(w) struct packed { logic borrow; logic [(w)-1:0] diff; }
`endif

package fixed_point_arith_pkg;

   function automatic int num_slices(input int n, input int w);
      return n / w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/csel_sub_slice.sv
// ============================================================================
// csel_sub_slice
// One W-bit carry-select subtract slice; both borrow-in variants computed, bsel picks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module csel_sub_slice
   import fixed_point_arith_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] a_k,
   input  logic [W-1:0] b_k,
   input  logic         bsel,
   output logic [W-1:0] diff,
   output logic         borrow
);

   typedef `FPA_SLICE_RES_T(W) slice_res_t;

   slice_res_t w_res0;
   slice_res_t w_res1;
   slice_res_t w_sel;

   // W+1-bit arithmetic: a negative result leaves a 1 in the MSB, which is the slice borrow.
   assign w_res0 = {1'b0, a_k} - {1'b0, b_k};
   assign w_res1 = {1'b0, a_k} - {1'b0, b_k} - (W+1)'(1);
   assign w_sel  = bsel ? w_res1 : w_res0;

   assign diff   = w_sel.diff;
   assign borrow = w_sel.borrow;

endmodule

`default_nettype wire

// File: rtl/pipelined_carry_select_sub.sv
// ============================================================================
// pipelined_carry_select_sub
// S-stage carry-select subtractor d = a - b - bi with borrow out, overflow and valid/ready.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipelined_carry_select_sub
   import fixed_point_arith_pkg::*;
#(
   parameter int N = 32,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bi,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] d,
   output logic         bo,
   output logic         ovf
);

   localparam int S = num_slices(N, W);

   if ((N % W) != 0 || W < 2) begin : g_param_check
      $fatal(1, "pipelined_carry_select_sub: N must be a multiple of W and W >= 2");
   end

   // Whole pipeline moves in lockstep; bubbles are kept, not squeezed out.
   logic w_adv;
   assign w_adv    = ~out_valid | out_ready;
   assign in_ready = w_adv;

   for (genvar k = 0; k < S; k++) begin : g_stage
      localparam int LO = k * W;
      localparam int RW = N - LO;

      logic [RW-1:0]   w_a;
      logic [RW-1:0]   w_b;
      logic            w_bin;
      logic            w_vin;
      logic [W-1:0]    w_diff;
      logic            w_bout;
      logic [LO+W-1:0] w_res;

      logic            r_vld;
      logic            r_borrow;
      logic [LO+W-1:0] r_diff;

      csel_sub_slice #(
         .W (W)
      ) u_slice (
         .a_k    (w_a[W-1:0]),
         .b_k    (w_b[W-1:0]),
         .bsel   (w_bin),
         .diff   (w_diff),
         .borrow (w_bout)
      );

      if (k == 0) begin : g_first
         assign w_a   = a;
         assign w_b   = b;
         assign w_bin = bi;
         assign w_vin = in_valid;
         assign w_res = w_diff;
      end else begin : g_next
         assign w_a   = g_stage[k-1].g_hi.r_a;
         assign w_b   = g_stage[k-1].g_hi.r_b;
         assign w_bin = g_stage[k-1].r_borrow;
         assign w_vin = g_stage[k-1].r_vld;
         assign w_res = {w_diff, g_stage[k-1].r_diff};
      end

      // Data only loads with a valid op, so outputs keep the last result across bubbles.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_vld    <= 1'b0;
            r_borrow <= 1'b0;
            r_diff   <= '0;
         end else if (w_adv) begin
            r_vld <= w_vin;
            if (w_vin) begin
               r_borrow <= w_bout;
               r_diff   <= w_res;
            end
         end
      end

      if (k < S - 1) begin : g_hi
         logic [RW-W-1:0] r_a;
         logic [RW-W-1:0] r_b;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_adv && w_vin) begin
               r_a <= w_a[RW-1:W];
               r_b <= w_b[RW-1:W];
            end
         end
      end else begin : g_last
         logic w_ovf;
         logic r_ovf;

         assign w_ovf = (w_a[W-1] != w_b[W-1]) && (w_diff[W-1] != w_a[W-1]);

         always_ff @(posedge clk) begin
            if (rst) begin
               r_ovf <= 1'b0;
            end else if (w_adv && w_vin) begin
               r_ovf <= w_ovf;
            end
         end
      end
   end

   assign out_valid = g_stage[S-1].r_vld;
   assign d         = g_stage[S-1].r_diff;
   assign bo        = g_stage[S-1].r_borrow;
   assign ovf       = g_stage[S-1].g_last.r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_carry_select_sub.sv
// ============================================================================
// tb_pipelined_carry_select_sub
// Scoreboard bench: expected results queued at accept, compared in order at output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipelined_carry_select_sub;

   localparam int N = 32;
   localparam int W = 8;
   localparam int S = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         bi;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] d;
   logic         bo;
   logic         ovf;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int outs   = 0;
   bit rnd_done = 1'b0;

   typedef struct {
      logic [N-1:0] d;
      logic         bo;
      logic         ovf;
      int           acc;
      bit           lat;
   } exp_t;

   exp_t sb[$];

   pipelined_carry_select_sub #(
      .N (N),
      .W (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bi        (bi),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .bo        (bo),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic tbi);
      logic [N:0] r;
      exp_t       e;
      r     = {1'b0, ta} - {1'b0, tb_} - {{N{1'b0}}, tbi};
      e.d   = r[N-1:0];
      e.bo  = r[N];
      e.ovf = (ta[N-1] != tb_[N-1]) && (e.d[N-1] != ta[N-1]);
      e.acc = 0;
      e.lat = 1'b0;
      return e;
   endfunction

   function automatic logic [N-1:0] rand_operand();
      logic [N-1:0] corners [4];
      corners[0] = '0;
      corners[1] = '1;
      corners[2] = 32'h8000_0000;
      corners[3] = 32'h7FFF_FFFF;
      if ($urandom_range(7) == 0) return corners[$urandom_range(3)];
      return $urandom;
   endfunction

   // Entered just after a rising edge; returns just after the edge that accepted the op.
   task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic tbi, input bit lat);
      exp_t e;
      bit   done;
      done  = 1'b0;
      e     = model(ta, tb_, tbi);
      e.lat = lat;
      a = ta; b = tb_; bi = tbi; in_valid = 1'b1;
      for (int i = 0; i < 1000 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            e.acc = cyc;
            sb.push_back(e);
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) check_eq("accept_timeout", 64'(done), 64'(1));
   endtask

   task automatic drain();
      for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) check_eq("drain_timeout", 64'(sb.size()), 64'(0));
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check_eq("stray_out", 64'(out_valid), 64'(0));
         end else begin
            e = sb.pop_front();
            check_eq("d", 64'(d), 64'(e.d));
            check_eq("bo", 64'(bo), 64'(e.bo));
            check_eq("ovf", 64'(ovf), 64'(e.ovf));
            if (e.lat) check_eq("latency", 64'(cyc - e.acc), 64'(S));
            outs++;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int outs0;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bi = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("rst_out_valid", 64'(out_valid), 64'(0));
      check_eq("rst_d", 64'(d), 64'(0));
      check_eq("rst_bo", 64'(bo), 64'(0));
      check_eq("rst_ovf", 64'(ovf), 64'(0));
      check_eq("rst_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk); #1;

      // Directed vectors, each with exact latency check.
      send(32'd5, 32'd3, 1'b0, 1'b1);
      drain();
      send(32'd0, 32'd1, 1'b0, 1'b1);
      send(32'd0, 32'd0, 1'b1, 1'b1);
      send(32'h8000_0000, 32'd1, 1'b0, 1'b1);
      send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
      send(32'h0100_0000, 32'd1, 1'b0, 1'b1);
      drain();

      // Stream of 8 with a 3-cycle downstream stall mid-stream.
      outs0 = outs;
      fork
         begin
            for (int i = 0; i < 8; i++) send(rand_operand(), rand_operand(), 1'($urandom), 1'b0);
         end
         begin : stall
            logic [N+2:0] held;
            bit           seen;
            seen = 1'b0;
            held = '0;
            for (int i = 0; i < 50 && !seen; i++) begin
               @(negedge clk);
               if (out_valid) seen = 1'b1;
            end
            if (!seen) check_eq("stall_no_output", 64'(seen), 64'(1));
            @(posedge clk); #1;
            out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               check_eq("stall_in_ready", 64'(in_ready), 64'(0));
               if (i == 0) begin
                  check_eq("stall_out_valid", 64'(out_valid), 64'(1));
                  held = {out_valid, d, bo, ovf};
               end else begin
                  check_eq("stall_hold", 64'({out_valid, d, bo, ovf}), 64'(held));
               end
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();
      check_eq("stall_count", 64'(outs - outs0), 64'(8));

      // Reset with three ops in flight: nothing stale may emerge afterwards.
      send(32'h1234_5678, 32'h0000_1111, 1'b0, 1'b0);
      send(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0);
      send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
      rst = 1'b1;
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("midrst_out_valid", 64'(out_valid), 64'(0));
      check_eq("midrst_d", 64'(d), 64'(0));
      check_eq("midrst_bo", 64'(bo), 64'(0));
      check_eq("midrst_ovf", 64'(ovf), 64'(0));
      repeat (6) @(posedge clk);
      #1;
      send(32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1);
      drain();

      // Random vectors with idle gaps and random back-pressure.
      fork
         begin
            for (int i = 0; i < 10000; i++) begin
               if ($urandom_range(3) == 0) begin
                  @(posedge clk); #1;
               end
               send(rand_operand(), rand_operand(), 1'($urandom), 1'b0);
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      drain();
      check_eq("sb_empty", 64'(sb.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
